// File: rtl/alu_regfile_sequencer_pkg.sv
// Shared types and widths for the alu_regfile datapath and its instruction sequencer.
package alu_regfile_sequencer_pkg;

    localparam int unsigned REGFILE_WIDTH      = 16;
    localparam int unsigned REGFILE_ADDR_WIDTH = 4;
    // One extra bit carries the ALU carry/borrow out.
    localparam int unsigned ALU_OUTPUT_WIDTH   = REGFILE_WIDTH + 1;
    // Wide enough for EXEC_CYCLES up to 15.
    localparam int unsigned EXEC_CNT_WIDTH     = 4;
    localparam int unsigned RETIRE_CNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ADD_OP  = 3'd0,
        SUB_OP  = 3'd1,
        AND_OP  = 3'd2,
        OR_OP   = 3'd3,
        EXOR_OP = 3'd4,
        NOT_OP  = 3'd5,
        SHL_OP  = 3'd6,
        SHR_OP  = 3'd7
    } aluop_t;

    typedef enum logic {
        ALU_INSTR   = 1'b0,
        LOADI_INSTR = 1'b1
    } instr_kind_t;

    typedef struct packed {
        instr_kind_t                   kind;
        aluop_t                        op;
        logic                          c_in;
        logic [REGFILE_ADDR_WIDTH-1:0] dst;
        logic [REGFILE_ADDR_WIDTH-1:0] src_a;
        logic [REGFILE_ADDR_WIDTH-1:0] src_b;
        logic [REGFILE_WIDTH-1:0]      imm;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_regfile_sequencer_instr_fifo.sv
// Small synchronous FIFO holding pending instructions; DEPTH must be a power of two.
module alu_regfile_sequencer_instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guard against overflow/underflow regardless of caller behaviour.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    // Storage array needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_regfile_sequencer.sv
// In-order sequencer feeding alu_regfile: queues instructions, drives operands, writes back.
module alu_regfile_sequencer
    import alu_regfile_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Instr_Valid,
    input  instr_t                        Instr_In,
    output logic                          Instr_Ready,
    output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
    output logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
    output aluop_t                        Opcode,
    output logic                          Carry_In,
    input  logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out,
    output logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
    output logic                          Write_enable,
    output logic [REGFILE_WIDTH-1:0]      Write_data,
    output logic                          Busy,
    output logic                          Retire,
    output logic [RETIRE_CNT_WIDTH-1:0]   Retired_Count
);

    localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [EXEC_CNT_WIDTH-1:0] ExecLoad = EXEC_CNT_WIDTH'(EXEC_CYCLES - 1);

    seq_state_t                    state_q, state_d;
    logic [EXEC_CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [REGFILE_ADDR_WIDTH-1:0] cur_dst_q, cur_dst_d;
    logic [REGFILE_ADDR_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    aluop_t                        op_q, op_d;
    logic                          cin_q, cin_d;
    logic                          we_q, we_d;
    logic [REGFILE_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [REGFILE_WIDTH-1:0]      result_q, result_d;
    logic [RETIRE_CNT_WIDTH-1:0]   retired_q, retired_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FifoCntW-1:0] fifo_count;
    instr_t              fifo_rdata;
    logic                dispatch;
    logic                unused_alu_hi;

    // Carry-out is not part of the register write.
    assign unused_alu_hi = ^ALU_Out[ALU_OUTPUT_WIDTH-1:REGFILE_WIDTH];

    // Ready depends only on occupancy, so a same-cycle pop never frees a full FIFO.
    assign Instr_Ready = !fifo_full;
    assign fifo_push   = Instr_Valid && Instr_Ready;

    alu_regfile_sequencer_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(instr_t))
    ) u_instr_fifo (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .push_i  (fifo_push),
        .wdata_i (Instr_In),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A new instruction may start from IDLE or straight out of WB (no bubble).
    assign dispatch = ((state_q == IDLE) || (state_q == WB)) && !fifo_empty;

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_dst_d = cur_dst_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        op_d      = op_q;
        cin_d     = cin_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        result_d  = result_q;
        retired_d = retired_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            ISSUE: begin
                cnt_d   = ExecLoad;
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    we_d     = 1'b1;
                    waddr_d  = cur_dst_q;
                    result_d = ALU_Out[REGFILE_WIDTH-1:0];
                    state_d  = WB;
                end else begin
                    cnt_d = cnt_q - EXEC_CNT_WIDTH'(1);
                end
            end
            WB: begin
                retired_d = retired_q + RETIRE_CNT_WIDTH'(1);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Operand outputs are loaded at pop so they are already stable during ISSUE.
        if (dispatch) begin
            fifo_pop = 1'b1;
            if (fifo_rdata.kind == LOADI_INSTR) begin
                we_d     = 1'b1;
                waddr_d  = fifo_rdata.dst;
                result_d = fifo_rdata.imm;
                state_d  = WB;
            end else begin
                cur_dst_d = fifo_rdata.dst;
                rd1_d     = fifo_rdata.src_a;
                rd2_d     = fifo_rdata.src_b;
                op_d      = fifo_rdata.op;
                cin_d     = fifo_rdata.c_in;
                state_d   = ISSUE;
            end
        end
    end

    // State and output registers; reset abandons any in-flight write.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_dst_q <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            op_q      <= ADD_OP;
            cin_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            result_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_dst_q <= cur_dst_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            op_q      <= op_d;
            cin_q     <= cin_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            result_q  <= result_d;
            retired_q <= retired_d;
        end
    end

    assign Read_Addr_1   = rd1_q;
    assign Read_Addr_2   = rd2_q;
    assign Opcode        = op_q;
    assign Carry_In      = cin_q;
    assign Write_Addr    = waddr_q;
    assign Write_enable  = we_q;
    assign Write_data    = result_q;
    assign Retire        = we_q;
    assign Retired_Count = retired_q;
    assign Busy          = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// Scoreboard bench: an ALU/regfile environment around the sequencer plus an in-order ISA model.
module tb_alu_regfile_sequencer;
    import alu_regfile_sequencer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Instr_Valid;
    instr_t      Instr_In;
    logic        Instr_Ready;
    logic [3:0]  Read_Addr_1, Read_Addr_2, Write_Addr;
    aluop_t      Opcode;
    logic        Carry_In;
    logic [16:0] ALU_Out;
    logic        Write_enable;
    logic [15:0] Write_data;
    logic        Busy, Retire;
    logic [15:0] Retired_Count;

    alu_regfile_sequencer #(
        .FIFO_DEPTH  (4),
        .EXEC_CYCLES (1)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Instr_Valid   (Instr_Valid),
        .Instr_In      (Instr_In),
        .Instr_Ready   (Instr_Ready),
        .Read_Addr_1   (Read_Addr_1),
        .Read_Addr_2   (Read_Addr_2),
        .Opcode        (Opcode),
        .Carry_In      (Carry_In),
        .ALU_Out       (ALU_Out),
        .Write_Addr    (Write_Addr),
        .Write_enable  (Write_enable),
        .Write_data    (Write_data),
        .Busy          (Busy),
        .Retire        (Retire),
        .Retired_Count (Retired_Count)
    );

    always #5 Clock = ~Clock;

    // ALU behaviour as seen by software: 16-bit result plus carry/borrow bit.
    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input aluop_t op, input logic cin);
        case (op)
            ADD_OP:  return {1'b0, a} + {1'b0, b} + 17'(cin);
            SUB_OP:  return {1'b0, a} - {1'b0, b} - 17'(cin);
            AND_OP:  return {1'b0, a & b};
            OR_OP:   return {1'b0, a | b};
            EXOR_OP: return {1'b0, a ^ b};
            NOT_OP:  return {1'b0, ~a};
            SHL_OP:  return {a, 1'b0};
            default: return {1'b0, a >> 1};
        endcase
    endfunction

    // Environment register file driven by the DUT.
    logic [15:0] env_regs [16];
    always @(posedge Clock) if (Write_enable) env_regs[Write_Addr] <= Write_data;
    assign ALU_Out = alu_f(env_regs[Read_Addr_1], env_regs[Read_Addr_2], Opcode, Carry_In);

    // Reference model state.
    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;
    exp_t        exp_q [$];
    logic [15:0] model_regs [16];
    logic [15:0] snap_regs [16];
    logic [15:0] model_retired;
    logic [15:0] model_issued;

    int n_cmp = 0;
    int n_fail = 0;
    int cycle = 0;
    int we_total = 0;
    int we_cycles [$];
    bit saw_full;
    exp_t mon_e;

    always @(posedge Clock) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic instr_t mk_alu(input aluop_t op, input logic [3:0] dst,
                                      input logic [3:0] a, input logic [3:0] b, input logic cin);
        instr_t i;
        i.kind = ALU_INSTR; i.op = op; i.c_in = cin;
        i.dst = dst; i.src_a = a; i.src_b = b; i.imm = 16'($urandom);
        return i;
    endfunction

    function automatic instr_t mk_loadi(input logic [3:0] dst, input logic [15:0] imm);
        instr_t i;
        i.kind = LOADI_INSTR; i.op = aluop_t'($urandom_range(0, 7)); i.c_in = 1'($urandom);
        i.dst = dst; i.src_a = 4'($urandom); i.src_b = 4'($urandom); i.imm = imm;
        return i;
    endfunction

    // In-order architectural model: each accepted instruction's write is known at accept time.
    task automatic model_accept(input instr_t ins);
        exp_t        e;
        logic [16:0] r;
        e.addr = ins.dst;
        if (ins.kind == LOADI_INSTR) begin
            e.data = ins.imm;
        end else begin
            r = alu_f(model_regs[ins.src_a], model_regs[ins.src_b], ins.op, ins.c_in);
            e.data = r[15:0];
        end
        model_regs[ins.dst] = e.data;
        model_issued++;
        exp_q.push_back(e);
    endtask

    task automatic send(input instr_t ins);
        int g = 0;
        @(negedge Clock);
        Instr_Valid = 1'b1;
        Instr_In = ins;
        while (!Instr_Ready && g < 200) begin
            saw_full = 1'b1;
            @(negedge Clock);
            g++;
        end
        check("send_timeout", 32'(g >= 200), 32'd0);
        @(posedge Clock);
        model_accept(ins);
    endtask

    task automatic idle_cycles(input int n);
        @(negedge Clock);
        Instr_Valid = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge Clock);
        while ((Busy || exp_q.size() != 0) && g < 1000) begin
            @(negedge Clock);
            g++;
        end
        check("drain_timeout", 32'(g >= 1000), 32'd0);
    endtask

    // Monitor: every write-back is popped from the scoreboard and compared.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (Write_enable) begin
                we_total++;
                we_cycles.push_back(cycle);
                check("retire_with_we", 32'(Retire), 32'd1);
                check("retired_count", 32'(Retired_Count), 32'(model_retired));
                model_retired++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none required",
                             Write_Addr, Write_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_addr", 32'(Write_Addr), 32'(mon_e.addr));
                    check("wb_data", 32'(Write_data), 32'(mon_e.data));
                end
            end else if (Retire) begin
                check("retire_without_we", 32'(Retire), 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(Write_enable), 32'd0);
        check({tag, "_retire"}, 32'(Retire), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_ready"}, 32'(Instr_Ready), 32'd1);
        check({tag, "_count"}, 32'(Retired_Count), 32'd0);
        check({tag, "_opcode"}, 32'(Opcode), 32'(ADD_OP));
        check({tag, "_addrs"}, 32'({Read_Addr_1, Read_Addr_2, Write_Addr}), 32'd0);
        check({tag, "_wdata_cin"}, 32'({Write_data, Carry_In}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        Instr_Valid = 1'b0;
        Instr_In = '0;
        model_retired = '0;
        model_issued = '0;
        for (int r = 0; r < 16; r++) begin
            env_regs[r] = '0;
            model_regs[r] = '0;
        end
        repeat (3) @(negedge Clock);
        check_reset_outputs("por");
        Reset = 1'b0;

        // 1: LOADI, LOADI, ADD
        begin
            int base;
            base = we_total;
            send(mk_loadi(4'd0, 16'h5555));
            send(mk_loadi(4'd1, 16'hAAAA));
            send(mk_alu(ADD_OP, 4'd2, 4'd0, 4'd1, 1'b0));
            idle_cycles(1);
            wait_idle();
            check("t1_r2", 32'(env_regs[2]), 32'hFFFF);
            check("t1_we_pulses", 32'(we_total - base), 32'd3);
            check("t1_retired", 32'(Retired_Count), 32'd3);
        end

        // 2: RAW chain
        send(mk_alu(SUB_OP, 4'd3, 4'd2, 4'd0, 1'b0));
        send(mk_alu(EXOR_OP, 4'd4, 4'd3, 4'd1, 1'b0));
        idle_cycles(1);
        wait_idle();
        check("t2_r3", 32'(env_regs[3]), 32'hAAAA);
        check("t2_r4", 32'(env_regs[4]), 32'h0000);

        // 3/4: back-to-back burst with Instr_Valid held through full
        we_cycles.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(mk_alu(aluop_t'($urandom_range(0, 7)), 4'($urandom_range(2, 7)),
                        4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 1'($urandom)));
        end
        idle_cycles(1);
        wait_idle();
        check("t3_we_count", 32'(we_cycles.size()), 32'd8);
        for (int i = 1; i < we_cycles.size(); i++)
            check("t3_we_spacing", 32'(we_cycles[i] - we_cycles[i-1]), 32'd3);
        check("t3_saw_not_ready", 32'(saw_full), 32'd1);

        // 6: every opcode on r0/r1 into r8..r15
        for (int k = 0; k < 8; k++)
            send(mk_alu(aluop_t'(k), 4'(8 + k), 4'd0, 4'd1, 1'($urandom)));
        idle_cycles(1);
        wait_idle();
        for (int k = 8; k < 16; k++) check("t6_reg", 32'(env_regs[k]), 32'(model_regs[k]));

        // 5: reset during EXEC of ADD r5
        snap_regs = model_regs;
        send(mk_alu(ADD_OP, 4'd5, 4'd0, 4'd1, 1'b0));
        @(negedge Clock);
        Instr_Valid = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        exp_q.delete();
        model_regs = snap_regs;
        model_retired = '0;
        model_issued = '0;
        #1;
        check_reset_outputs("mid_exec");
        repeat (2) @(negedge Clock);
        check("t5_r5_unchanged", 32'(env_regs[5]), 32'(snap_regs[5]));
        Reset = 1'b0;

        // Random traffic with gaps, then full architectural comparison
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                send(mk_loadi(4'($urandom), 16'($urandom)));
            else
                send(mk_alu(aluop_t'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                            4'($urandom), 1'($urandom)));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(0, 5));
        end
        idle_cycles(1);
        wait_idle();
        for (int r = 0; r < 16; r++) check("final_reg", 32'(env_regs[r]), 32'(model_regs[r]));
        check("final_retired", 32'(Retired_Count), 32'(model_issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
